// File: rtl/register_file_if.sv
// Bus bundle for register_file: write port, two read addresses and the registered read data.
interface register_file_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             clr;
  logic             w;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] qb;

  modport master (
    output clr, w, waddr, d, raddr_a, raddr_b,
    input  qa, qb
  );

  modport slave (
    input  clr, w, waddr, d, raddr_a, raddr_b,
    output qa, qb
  );
endinterface

// File: rtl/register_file.sv
// Two-read/one-write register file with registered outputs and synchronous clear.
// Define REGISTER_FILE_BYPASS_EN for write-through on a same-edge read of the written address.
module register_file #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  register_file_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] qa_q, qb_q;
  logic [WIDTH-1:0] qa_d, qb_d;
  logic             we;

  // Widened compare so non-power-of-two depths are checked without constant-fold warnings.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic readable(input logic [AW-1:0] a);
    return in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    we   = bus.w && !bus.clr && readable(bus.waddr);
    qa_d = '0;
    qb_d = '0;
    if (!bus.clr && readable(bus.raddr_a)) begin
      if (BYPASS && we && (bus.raddr_a == bus.waddr)) qa_d = bus.d;
      else                                             qa_d = mem[bus.raddr_a];
    end
    if (!bus.clr && readable(bus.raddr_b)) begin
      if (BYPASS && we && (bus.raddr_b == bus.waddr)) qb_d = bus.d;
      else                                             qb_d = mem[bus.raddr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa_q <= '0;
      qb_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
      if (bus.clr) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
        mem[bus.waddr] <= bus.d;
      end
    end
  end

  assign bus.qa = qa_q;
  assign bus.qb = qb_q;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: three register_file variants (8/8/zero, 8/6/zero, 8/8/no-zero) on shared stimulus.
module tb_register_file;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr, w;
  logic [2:0] wa, ra, rb;
  logic [7:0] d;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  register_file_if #(.WIDTH(8), .DEPTH(8)) bus0 ();
  register_file_if #(.WIDTH(8), .DEPTH(6)) bus6 ();
  register_file_if #(.WIDTH(8), .DEPTH(8)) busz ();

  assign bus0.clr = clr;  assign bus6.clr = clr;  assign busz.clr = clr;
  assign bus0.w = w;      assign bus6.w = w;      assign busz.w = w;
  assign bus0.waddr = wa; assign bus6.waddr = wa; assign busz.waddr = wa;
  assign bus0.d = d;      assign bus6.d = d;      assign busz.d = d;
  assign bus0.raddr_a = ra; assign bus6.raddr_a = ra; assign busz.raddr_a = ra;
  assign bus0.raddr_b = rb; assign bus6.raddr_b = rb; assign busz.raddr_b = rb;

  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  register_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0)) dutz (.clk(clk), .rst_n(rst_n), .bus(busz));

  // Reference model: plain arrays, one per variant.
  int unsigned depth_k [3] = '{8, 6, 8};
  bit          zr_k    [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0]  mdl     [3][8];

  typedef struct {
    bit         clr;
    bit         w;
    logic [2:0] wa;
    logic [7:0] d;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] eqa;
    logic [7:0] eqb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_q(input int k, input bit port_b);
    case (k)
      0:       return port_b ? bus0.qb : bus0.qa;
      1:       return port_b ? bus6.qb : bus6.qa;
      default: return port_b ? busz.qb : busz.qa;
    endcase
  endfunction

  function automatic logic [7:0] mdl_read(input int k, input logic [2:0] a);
    if (32'(a) >= depth_k[k]) return 8'h00;
    if (zr_k[k] && a == 3'd0) return 8'h00;
    return mdl[k][a];
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) mdl[k][i] = 8'h00;
  endtask

  // One clock edge with the currently driven inputs; every variant compared to the model.
  task automatic step();
    logic [7:0] eqa [3];
    logic [7:0] eqb [3];
    bit         wv;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        eqa[k] = 8'h00;
        eqb[k] = 8'h00;
        for (int i = 0; i < 8; i++) mdl[k][i] = 8'h00;
      end else begin
        wv = w && (32'(wa) < depth_k[k]) && !(zr_k[k] && wa == 3'd0);
        eqa[k] = (BYP && wv && ra == wa) ? d : mdl_read(k, ra);
        eqb[k] = (BYP && wv && rb == wa) ? d : mdl_read(k, rb);
        if (wv) mdl[k][wa] = d;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model dut%0d qa", k), get_q(k, 1'b0), eqa[k]);
      chk($sformatf("model dut%0d qb", k), get_q(k, 1'b1), eqb[k]);
    end
  endtask

  task automatic drive(input bit c, input bit we, input logic [2:0] a_w, input logic [7:0] dat,
                       input logic [2:0] a_a, input logic [2:0] a_b);
    clr = c; w = we; wa = a_w; d = dat; ra = a_a; rb = a_b;
  endtask

  task automatic chk_all_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d qa", name, k), get_q(k, 1'b0), 8'h00);
      chk($sformatf("%s dut%0d qb", name, k), get_q(k, 1'b1), 8'h00);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 1, 3'd5, 8'h3C, 3'd5, 3'd5, BYP ? 8'h3C : 8'h00, BYP ? 8'h3C : 8'h00};
    tbl[1]  = '{0, 0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h3C, 8'h3C};
    tbl[2]  = '{0, 1, 3'd0, 8'hFF, 3'd0, 3'd5, 8'h00, 8'h3C};
    tbl[3]  = '{0, 0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00};
    tbl[4]  = '{0, 1, 3'd2, 8'h11, 3'd1, 3'd2, 8'h00, BYP ? 8'h11 : 8'h00};
    tbl[5]  = '{0, 1, 3'd2, 8'h22, 3'd2, 3'd5, BYP ? 8'h22 : 8'h11, 8'h3C};
    tbl[6]  = '{0, 0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h22, 8'h22};
    tbl[7]  = '{0, 1, 3'd4, 8'h44, 3'd7, 3'd3, 8'h00, 8'h00};
    tbl[8]  = '{0, 1, 3'd7, 8'h77, 3'd4, 3'd6, 8'h44, 8'h00};
    tbl[9]  = '{1, 1, 3'd4, 8'h99, 3'd4, 3'd7, 8'h00, 8'h00};
    tbl[10] = '{0, 0, 3'd0, 8'h00, 3'd4, 3'd7, 8'h00, 8'h00};
    tbl[11] = '{0, 0, 3'd0, 8'h00, 3'd2, 3'd5, 8'h00, 8'h00};

    drive(0, 0, 3'd0, 8'h00, 3'd0, 3'd0);
    mdl_clear();
    #2;
    chk_all_zero("reset state");
    #10 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].clr, tbl[i].w, tbl[i].wa, tbl[i].d, tbl[i].ra, tbl[i].rb);
      step();
      chk($sformatf("vec%0d qa", i), bus0.qa, tbl[i].eqa);
      chk($sformatf("vec%0d qb", i), bus0.qb, tbl[i].eqb);
    end

    // Zero register: only the ZERO_REG=0 variant keeps the write to address 0.
    drive(0, 1, 3'd0, 8'hFF, 3'd1, 3'd1);
    step();
    drive(0, 0, 3'd0, 8'h00, 3'd0, 3'd0);
    step();
    chk("zero reg on", bus0.qa, 8'h00);
    chk("zero reg off", busz.qa, 8'hFF);

    // Clear priority over a coincident write.
    for (int i = 1; i < 8; i++) begin
      drive(0, 1, 3'(i), 8'(i * 17), 3'd0, 3'd0);
      step();
    end
    drive(1, 1, 3'd4, 8'h99, 3'd4, 3'd7);
    step();
    chk("clr edge qa", bus0.qa, 8'h00);
    chk("clr edge qb", bus0.qb, 8'h00);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      step();
      chk($sformatf("after clr reg%0d", i), bus0.qa, 8'h00);
    end

    // Out of range on DEPTH=6.
    for (int i = 1; i < 6; i++) begin
      drive(0, 1, 3'(i), 8'(8'h60 + i), 3'd0, 3'd0);
      step();
    end
    drive(0, 1, 3'd6, 8'h77, 3'd6, 3'd7);
    step();
    drive(0, 1, 3'd7, 8'h77, 3'd7, 3'd6);
    step();
    drive(0, 0, 3'd0, 8'h00, 3'd7, 3'd6);
    step();
    chk("oor read 7", bus6.qa, 8'h00);
    chk("oor read 6", bus6.qb, 8'h00);
    for (int i = 1; i < 6; i++) begin
      drive(0, 0, 3'd0, 8'h00, 3'(i), 3'd0);
      step();
      chk($sformatf("oor keep reg%0d", i), bus6.qa, 8'(8'h60 + i));
    end

    // Asynchronous reset mid-cycle, with a write pending while held.
    drive(0, 1, 3'd3, 8'hA5, 3'd0, 3'd0);
    step();
    drive(0, 0, 3'd0, 8'h00, 3'd3, 3'd3);
    step();
    chk("pre-reset reg3", bus0.qa, 8'hA5);
    #3 rst_n = 1'b0;
    drive(0, 1, 3'd3, 8'h5A, 3'd3, 3'd3);
    #1;
    chk_all_zero("async reset");
    mdl_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("held reset");
    #3 rst_n = 1'b1;
    drive(0, 0, 3'd0, 8'h00, 3'd3, 3'd3);
    step();
    chk("post-reset reg3 a", bus0.qa, 8'h00);
    chk("post-reset reg3 b", bus0.qb, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      clr = ($urandom_range(0, 24) == 0);
      w   = 1'($urandom_range(0, 1));
      wa  = 3'($urandom);
      d   = 8'($urandom);
      ra  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
